// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arbiter_pkg
// Purpose  : Shared types and encodings for the fetch/data memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  // Which requester owns an outstanding read.
  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  // Bit positions inside the two-bit request/grant vectors.
  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_D  = 1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/arb_prio.sv
`default_nettype none
// ============================================================================
// Module   : arb_prio
// Purpose  : Two-way priority pick. Data wins unless the data run has reached
//            its limit while fetch is waiting, in which case fetch wins.
// Revision : 1.0  initial release
// ============================================================================
module arb_prio
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,       // [GNT_IF]=fetch, [GNT_D]=data
  input  logic       i_at_limit,  // data run counter has hit its maximum
  output logic [1:0] o_grant      // one-hot (or zero) grant
);

  // Fetch takes the slot when alone or when starvation override applies.
  always_comb begin
    o_grant         = 2'b00;
    o_grant[GNT_IF] = i_req[GNT_IF] & (~i_req[GNT_D] | i_at_limit);
    o_grant[GNT_D]  = i_req[GNT_D] & ~o_grant[GNT_IF];
  end

endmodule : arb_prio
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous RAM between instruction fetch
//            and load/store. Data is favoured, a run-length counter bounds
//            fetch starvation, and read data returns to its owner one cycle
//            after grant.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch port
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  // data port
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W/8-1:0] i_d_mask,
  input  logic [DATA_W-1:0]   i_d_wdata,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  // RAM port
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W/8-1:0] o_mem_mask,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int               MASK_W    = DATA_W / 8;
  localparam int               CNT_W     = $clog2(MAX_DATA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_DATA_RUN);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             rd_pend_q, rd_pend_d;
  owner_e           rd_owner_q, rd_owner_d;

  logic [1:0]       prio_grant;
  logic             if_gnt;
  logic             d_gnt;

  arb_prio u_prio (
    .i_req      ({i_d_req, i_if_req}),
    .i_at_limit (run_cnt_q == RUN_LIMIT),
    .o_grant    (prio_grant)
  );

  // No grant may leave the arbiter while reset is held.
  assign if_gnt   = rst_n & prio_grant[GNT_IF];
  assign d_gnt    = rst_n & prio_grant[GNT_D];
  assign o_if_gnt = if_gnt;
  assign o_d_gnt  = d_gnt;

  // Route the winner's payload to the RAM; fetches are always plain reads.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_mask  = '0;
    o_mem_wdata = '0;
    if (d_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_mask  = i_d_mask;
      o_mem_wdata = i_d_wdata;
    end else if (if_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_if_addr;
      o_mem_mask  = {MASK_W{1'b0}};
    end
  end

  // Next-state for starvation counter and the read-return tracker.
  always_comb begin
    run_cnt_d  = run_cnt_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;

    if (!i_if_req || if_gnt) begin
      run_cnt_d = '0;
    end else if (d_gnt && (run_cnt_q != RUN_LIMIT)) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end

    if (d_gnt && !i_d_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = OWNER_D;
    end else if (if_gnt) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = OWNER_IF;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_IF;
    end else begin
      run_cnt_q  <= run_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read data is broadcast; only the owner's valid is raised.
  assign o_if_rvalid = rst_n & rd_pend_q & (rd_owner_q == OWNER_IF);
  assign o_d_rvalid  = rst_n & rd_pend_q & (rd_owner_q == OWNER_D);
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed scenarios followed
//            by constrained-random traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W       = 30;
  localparam int DATA_W       = 32;
  localparam int MASK_W       = DATA_W / 8;
  localparam int MAX_DATA_RUN = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt, o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_d_req, i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [MASK_W-1:0] i_d_mask;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_gnt, o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_mem_en, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [MASK_W-1:0] o_mem_mask;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_RUN(MAX_DATA_RUN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_mask(i_d_mask),
    .i_d_wdata(i_d_wdata), .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid),
    .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_mask(o_mem_mask), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous read, byte-masked write.
  logic [DATA_W-1:0] ram [256];
  always @(posedge clk) begin
    if (o_mem_en) begin
      if (o_mem_we) begin
        for (int b = 0; b < MASK_W; b++)
          if (o_mem_mask[b]) ram[o_mem_addr[7:0]][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
      end else begin
        i_mem_rdata <= ram[o_mem_addr[7:0]];
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [256];
  bit                m_pend;
  bit                m_owner_d;
  logic [DATA_W-1:0] m_data;
  int                m_starve;     // consecutive data wins while fetch waits
  bit                last_if_gnt, last_d_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the current cycle against the model, then advance.
  task automatic step();
    bit                e_if, e_d, n_pend, n_owner_d;
    logic [DATA_W-1:0] n_data;
    int                n_starve;
    #1;
    last_if_gnt = o_if_gnt;
    last_d_gnt  = o_d_gnt;
    if (!rst_n) begin
      chk("rst_if_gnt", o_if_gnt, 0);
      chk("rst_d_gnt", o_d_gnt, 0);
      chk("rst_mem_en", o_mem_en, 0);
      chk("rst_mem_we", o_mem_we, 0);
      chk("rst_if_rvalid", o_if_rvalid, 0);
      chk("rst_d_rvalid", o_d_rvalid, 0);
      n_pend = 0; n_owner_d = 0; n_data = '0; n_starve = 0;
    end else begin
      e_if = i_if_req && (!i_d_req || m_starve == MAX_DATA_RUN);
      e_d  = i_d_req && !e_if;
      chk("if_gnt", o_if_gnt, e_if);
      chk("d_gnt", o_d_gnt, e_d);
      chk("mem_en", o_mem_en, e_if | e_d);
      if (!(e_if | e_d)) chk("mem_we_idle", o_mem_we, 0);
      if (e_d) begin
        chk("mem_we", o_mem_we, i_d_we);
        chk("mem_addr_d", o_mem_addr, i_d_addr);
        if (i_d_we) begin
          chk("mem_mask", o_mem_mask, i_d_mask);
          chk("mem_wdata", o_mem_wdata, i_d_wdata);
        end
      end
      if (e_if) begin
        chk("mem_we_if", o_mem_we, 0);
        chk("mem_mask_if", o_mem_mask, 0);
        chk("mem_addr_if", o_mem_addr, i_if_addr);
      end
      chk("if_rvalid", o_if_rvalid, m_pend && !m_owner_d);
      chk("d_rvalid", o_d_rvalid, m_pend && m_owner_d);
      if (m_pend && m_owner_d)  chk("d_rdata", o_d_rdata, m_data);
      if (m_pend && !m_owner_d) chk("if_rdata", o_if_rdata, m_data);

      n_pend    = e_if || (e_d && !i_d_we);
      n_owner_d = e_d;
      n_data    = e_d ? ref_mem[i_d_addr[7:0]] : ref_mem[i_if_addr[7:0]];
      if (e_d && i_d_we)
        for (int b = 0; b < MASK_W; b++)
          if (i_d_mask[b]) ref_mem[i_d_addr[7:0]][b*8 +: 8] = i_d_wdata[b*8 +: 8];
      if (!i_if_req || e_if) n_starve = 0;
      else if (e_d)          n_starve = (m_starve < MAX_DATA_RUN) ? m_starve + 1 : m_starve;
      else                   n_starve = m_starve;
    end
    @(posedge clk);
    m_pend = n_pend; m_owner_d = n_owner_d; m_data = n_data; m_starve = n_starve;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_if_req = 0; i_if_addr = '0;
    i_d_req = 0; i_d_we = 0; i_d_addr = '0; i_d_mask = '0; i_d_wdata = '0;
  endtask

  initial begin
    logic [5:0] fetch_pat;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    m_pend = 0; m_owner_d = 0; m_data = '0; m_starve = 0;
    i_mem_rdata = '0;
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    step(); step();
    rst_n = 1;

    // Fetch alone from 0x10.
    i_if_req = 1; i_if_addr = 30'h10;
    step();
    idle_inputs();
    #1;
    chk("fetch_rvalid", o_if_rvalid, 1);
    chk("fetch_rdata", o_if_rdata, 32'hDEADBEEF);
    chk("fetch_no_d_rvalid", o_d_rvalid, 0);
    step();

    // Simultaneous request: data load 0x20 wins, fetch next cycle.
    i_if_req = 1; i_if_addr = 30'h11; i_d_req = 1; i_d_addr = 30'h20;
    step();
    i_d_req = 0;
    step();
    idle_inputs();
    step();

    // Starvation bound: D,D,D,D,IF,D.
    fetch_pat = 6'b010000;
    i_if_req = 1; i_if_addr = 30'h3; i_d_req = 1; i_d_addr = 30'h4;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("starve_pat", last_if_gnt, fetch_pat[k]);
      if (k == 4) chk("run_cnt_after_if", dut.run_cnt_q, 0);
    end
    idle_inputs();
    step();

    // Masked store then load back.
    i_d_req = 1; i_d_we = 1; i_d_addr = 30'h8; i_d_mask = 4'b0010; i_d_wdata = 32'h0000AB00;
    step();
    i_d_we = 0; i_d_mask = '0; i_d_wdata = '0;
    step();
    idle_inputs();
    #1;
    chk("store_byte", o_d_rdata[15:8], 8'hAB);
    step();

    // Back-to-back loads 1,2,3.
    for (int a = 1; a <= 3; a++) begin
      i_d_req = 1; i_d_addr = ADDR_W'(a);
      step();
    end
    idle_inputs();
    step(); step();

    // Fetch granted, then reset in the following cycle.
    i_if_req = 1; i_if_addr = 30'h10;
    step();
    rst_n = 0; i_d_req = 1; i_d_addr = 30'h5;
    step(); step();
    rst_n = 1;
    #1;
    chk("run_cnt_post_rst", dut.run_cnt_q, 0);
    step();
    idle_inputs();
    step();

    // Random traffic honouring the hold-until-grant handshake.
    for (int n = 0; n < 400; n++) begin
      if (!i_if_req || last_if_gnt) begin
        i_if_req  = ($urandom_range(0, 3) != 0);
        i_if_addr = ADDR_W'($urandom_range(0, 15));
      end
      if (!i_d_req || last_d_gnt) begin
        i_d_req   = ($urandom_range(0, 3) != 0);
        i_d_we    = ($urandom_range(0, 2) == 0);
        i_d_addr  = ADDR_W'($urandom_range(0, 15));
        i_d_mask  = MASK_W'($urandom);
        i_d_wdata = $urandom;
      end
      if (n == 200) rst_n = 0;
      if (n == 202) rst_n = 1;
      step();
      if (!rst_n) begin last_if_gnt = 1; last_d_gnt = 1; end
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
